// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time instruction memory loader.
//   loader_state_t : top-level loader FSM states
//   LEN_BYTES      : number of bytes in the little-endian word-count field
//   BYTES_PER_WORD : bytes per instruction word (instruction width / 8)
//   csum_add       : 8-bit modular accumulate used for the frame checksum
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int WORD_BITS      = 32;
    localparam int LEN_BYTES      = 4;
    localparam int BYTES_PER_WORD = WORD_BITS / 8;

    typedef enum logic [2:0] {
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    // The checksum is a plain byte sum that wraps at 256.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte stream, the imem write port and the status lines of the
// loader.
//   master : host side (drives in_data/in_valid/reload, observes the rest)
//   slave  : loader side (imem_loader itself)
// Signals:
//   in_data[7:0], in_valid, in_ready : byte stream handshake
//   reload                           : restart request from DONE/ERR
//   imem_we, imem_addr, imem_wdata   : instruction memory write port
//   cpu_rst, done, err               : core reset and load status
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
);

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [AWIDTH-1:0] imem_addr;
    logic [DWIDTH-1:0] imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    modport master (
        output in_data,
        output in_valid,
        output reload,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_rst,
        input  done,
        input  err
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  reload,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_rst,
        output done,
        output err
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Little-endian byte-to-word assembler used for both the length field and
// the instruction words. The first three bytes of a word are held in a
// shift register; the fourth byte is merged combinationally so the parent
// can register the complete word on the same edge that accepts that byte.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   clear       : synchronous restart of the byte counter and register
//   byte_en     : a byte is accepted this cycle
//   in_byte     : the byte being accepted
//   word_out    : assembled word, valid while word_valid is high
//   word_valid  : high in the cycle the 4th byte of a word is accepted
// ---------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
#(
    parameter int WIDTH = WORD_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_en,
    input  logic [7:0]       in_byte,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [WIDTH-9:0] shreg;
    logic [1:0]       byte_cnt;

    // Each new byte enters at the top and older bytes slide down, so once a
    // word is complete byte 0 sits in the lowest lane.
    assign word_out   = {in_byte, shreg};
    assign word_valid = byte_en && (byte_cnt == LAST_BYTE);

    // Byte counter and partial-word register. The counter wraps naturally at
    // the end of every word, so the parent only needs clear on a reload.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg    <= '0;
            byte_cnt <= 2'd0;
        end else if (byte_en) begin
            shreg    <= {in_byte, shreg[WIDTH-9:8]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader. Receives a frame of
//   4-byte LE word count N, 4*N LE data bytes, 1 checksum byte
// writes the words into instruction memory starting at word 0 and keeps the
// core in reset until the image is complete and the byte-sum checksum
// matches.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : imem_loader_if.slave (byte stream, imem write port, status)
// Parameters:
//   DWIDTH   : instruction width, fixed at 32
//   AWIDTH   : imem word address width (capacity 2**AWIDTH words)
// ---------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    localparam logic [DWIDTH-1:0] CAPACITY = DWIDTH'(1) << AWIDTH;

    loader_state_t     state;
    logic [AWIDTH:0]   addr_cnt;
    logic [AWIDTH:0]   n_words;
    logic [7:0]        csum;

    logic              in_ready_r;
    logic              imem_we_r;
    logic [AWIDTH-1:0] imem_addr_r;
    logic [DWIDTH-1:0] imem_wdata_r;
    logic              cpu_rst_r;
    logic              done_r;
    logic              err_r;

    logic              accept;
    logic              pack_en;
    logic              pack_clear;
    logic              word_valid;
    logic [DWIDTH-1:0] word_out;

    // A byte is taken whenever the host offers one and the loader is in a
    // receiving state; only the length and data phases feed the packer.
    assign accept     = bus.in_valid && in_ready_r;
    assign pack_en    = accept && ((state == LEN) || (state == DATA));
    assign pack_clear = bus.reload && ((state == DONE) || (state == ERR));

    byte_packer #(
        .WIDTH      (DWIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .byte_en    (pack_en),
        .in_byte    (bus.in_data),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

    assign bus.in_ready   = in_ready_r;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign bus.cpu_rst    = cpu_rst_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;

    // Loader FSM with all outputs registered. The address counter is one bit
    // wider than the imem address so a full 2**AWIDTH-word image can be
    // counted to completion. The write strobe defaults low every cycle so it
    // is a single-cycle pulse per assembled word. Status outputs are updated
    // on the same edge that moves the state, so they always track it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LEN;
            addr_cnt     <= '0;
            n_words      <= '0;
            csum         <= 8'd0;
            in_ready_r   <= 1'b1;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= '0;
            cpu_rst_r    <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            case (state)
                LEN: begin
                    if (accept) begin
                        csum <= csum_add(csum, bus.in_data);
                        if (word_valid) begin
                            if (word_out == '0) begin
                                state <= CSUM;
                            end else if (word_out > CAPACITY) begin
                                state      <= ERR;
                                err_r      <= 1'b1;
                                in_ready_r <= 1'b0;
                            end else begin
                                state   <= DATA;
                                n_words <= word_out[AWIDTH:0];
                            end
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum <= csum_add(csum, bus.in_data);
                        if (word_valid) begin
                            imem_we_r    <= 1'b1;
                            imem_addr_r  <= addr_cnt[AWIDTH-1:0];
                            imem_wdata_r <= word_out;
                            addr_cnt     <= addr_cnt + 1'b1;
                            if ((addr_cnt + 1'b1) == n_words) begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        in_ready_r <= 1'b0;
                        if (csum == bus.in_data) begin
                            state     <= DONE;
                            done_r    <= 1'b1;
                            cpu_rst_r <= 1'b0;
                        end else begin
                            state <= ERR;
                            err_r <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (bus.reload) begin
                        state       <= LEN;
                        addr_cnt    <= '0;
                        n_words     <= '0;
                        csum        <= 8'd0;
                        imem_addr_r <= '0;
                        in_ready_r  <= 1'b1;
                        cpu_rst_r   <= 1'b1;
                        done_r      <= 1'b0;
                        err_r       <= 1'b0;
                    end
                end
                default: begin
                    state      <= LEN;
                    in_ready_r <= 1'b1;
                    cpu_rst_r  <= 1'b1;
                    done_r     <= 1'b0;
                    err_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader (AWIDTH=2, capacity 4 words). A
// frame-level reference model tracks the accepted byte stream and derives
// the expected write port and status outputs from each byte's position in
// the frame; the DUT is compared against it every cycle. Directed frames
// add literal expectations, followed by randomized frames.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_loader_if #(.DWIDTH(32), .AWIDTH(AW)) bus ();

    imem_loader #(
        .DWIDTH (32),
        .AWIDTH (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_frame[$];
    int          m_status;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_wdata;

    logic [7:0]  frame_q[$];
    int          dut_addr_log[$];
    logic [31:0] dut_data_log[$];

    // Single comparison point: counts every check and reports mismatches.
    function automatic void check(input string name, input logic [63:0] actual,
                                  input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Reference model: the frame is a list of accepted bytes, and what must
    // happen is decided purely by the position of the newest byte. Status is
    // 0 while loading, 1 when done, 2 on error.
    function automatic void modelStep(input bit v, input logic [7:0] d,
                                      input bit rl, input bit r);
        int          len;
        longint      n;
        longint      db;
        int          sum;
        m_we = 1'b0;
        if (r) begin
            m_frame.delete();
            m_status = 0;
            m_addr   = 0;
            m_wdata  = 32'h0;
        end else if (m_status != 0) begin
            if (rl) begin
                m_status = 0;
                m_frame.delete();
            end
        end else if (v) begin
            m_frame.push_back(d);
            len = m_frame.size();
            if (len >= 4) begin
                n = longint'({m_frame[3], m_frame[2], m_frame[1], m_frame[0]});
                if (len == 4) begin
                    if (n > CAP) m_status = 2;
                end else begin
                    db = len - 4;
                    if (db <= 4 * n) begin
                        if (db % 4 == 0) begin
                            m_we    = 1'b1;
                            m_addr  = int'(db / 4 - 1);
                            m_wdata = {m_frame[len-1], m_frame[len-2],
                                       m_frame[len-3], m_frame[len-4]};
                        end
                    end else begin
                        sum = 0;
                        for (int i = 0; i < len - 1; i++) sum += int'(m_frame[i]);
                        m_status = ((sum % 256) == int'(m_frame[len-1])) ? 1 : 2;
                    end
                end
            end
        end
    endfunction

    // Per-cycle comparison of the DUT against the model, and capture of the
    // writes the DUT actually made for the directed literal checks.
    task automatic checkOutput();
        check("in_ready", bus.in_ready, (m_status == 0));
        check("done",     bus.done,     (m_status == 1));
        check("err",      bus.err,      (m_status == 2));
        check("cpu_rst",  bus.cpu_rst,  (m_status != 1));
        check("imem_we",  bus.imem_we,  m_we);
        if (m_we) begin
            check("imem_addr",  bus.imem_addr,  m_addr);
            check("imem_wdata", bus.imem_wdata, m_wdata);
        end
        if (bus.imem_we === 1'b1) begin
            dut_addr_log.push_back(int'(bus.imem_addr));
            dut_data_log.push_back(bus.imem_wdata);
        end
    endtask

    // Drives one clock cycle of inputs (entered and left at a falling edge),
    // advances the model for that cycle and checks the registered outputs.
    task automatic applyStimulus(input bit v, input logic [7:0] d,
                                 input bit rl, input bit r);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.reload   = rl;
        rst          = r;
        modelStep(v, d, rl, r);
        @(negedge clk);
        checkOutput();
    endtask

    function automatic bit randReload();
        return (m_status == 0) && ($urandom_range(0, 9) == 0);
    endfunction

    task automatic clearLogs();
        dut_addr_log.delete();
        dut_data_log.delete();
    endtask

    // Builds a frame for n words; oversize counts get a few trailing bytes
    // that the loader must refuse.
    task automatic makeFrame(input longint n, input bit corrupt);
        int sum;
        logic [31:0] n32;
        n32 = n[31:0];
        frame_q.delete();
        for (int i = 0; i < 4; i++) frame_q.push_back(n32[8*i +: 8]);
        if (n > CAP) begin
            for (int i = 0; i < 3; i++) frame_q.push_back(8'($urandom));
        end else begin
            for (longint i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
            sum = 0;
            foreach (frame_q[i]) sum += int'(frame_q[i]);
            if (corrupt) frame_q.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
            else         frame_q.push_back(8'(sum));
        end
    endtask

    // Sends frame_q with random idle gaps; rst_at >= 0 replaces that byte
    // with a reset cycle and abandons the rest of the frame.
    task automatic runFrame(input int gap_pct, input int rst_at);
        for (int i = 0; i < frame_q.size(); i++) begin
            while ($urandom_range(0, 99) < gap_pct)
                applyStimulus(1'b0, 8'($urandom), randReload(), 1'b0);
            if (i == rst_at) begin
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
                return;
            end
            applyStimulus(1'b1, frame_q[i], randReload(), 1'b0);
        end
    endtask

    task automatic doReload();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_we"},       bus.imem_we,    1'b0);
        check({tag, "_addr"},     bus.imem_addr,  0);
        check({tag, "_wdata"},    bus.imem_wdata, 32'h0);
        check({tag, "_cpu_rst"},  bus.cpu_rst,    1'b1);
        check({tag, "_done"},     bus.done,       1'b0);
        check({tag, "_err"},      bus.err,        1'b0);
        check({tag, "_in_ready"}, bus.in_ready,   1'b1);
    endtask

    // Main sequence: reset, directed frames with literal expectations, then
    // randomized frames with checksum corruption, gaps and mid-frame resets.
    initial begin
        int r;
        longint n;
        int rst_at;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.reload   = 1'b0;
        rst          = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkResetValues("reset");

        $display("[TB] single word");
        clearLogs();
        frame_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h00, 8'h01, 8'hB9};
        runFrame(0, -1);
        check("t1_done",    bus.done,    1'b1);
        check("t1_cpu_rst", bus.cpu_rst, 1'b0);
        check("t1_nwrites", dut_addr_log.size(), 1);
        if (dut_addr_log.size() == 1) begin
            check("t1_addr",  dut_addr_log[0], 0);
            check("t1_wdata", dut_data_log[0], 32'h010000B7);
        end
        doReload();

        $display("[TB] two words with gaps");
        clearLogs();
        frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h00, 8'h01,
                    8'h97, 8'h10, 8'h00, 8'h00, 8'h61};
        runFrame(40, -1);
        check("t2_done",    bus.done, 1'b1);
        check("t2_nwrites", dut_addr_log.size(), 2);
        if (dut_addr_log.size() == 2) begin
            check("t2_addr0",  dut_addr_log[0], 0);
            check("t2_wdata0", dut_data_log[0], 32'h010000B7);
            check("t2_addr1",  dut_addr_log[1], 1);
            check("t2_wdata1", dut_data_log[1], 32'h00001097);
        end
        doReload();

        $display("[TB] bad checksum");
        clearLogs();
        frame_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h00, 8'h01, 8'hB8};
        runFrame(0, -1);
        check("t3_err",      bus.err,      1'b1);
        check("t3_cpu_rst",  bus.cpu_rst,  1'b1);
        check("t3_in_ready", bus.in_ready, 1'b0);
        check("t3_nwrites",  dut_addr_log.size(), 1);
        doReload();
        frame_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h00, 8'h01, 8'hB9};
        runFrame(0, -1);
        check("t3_done_after_reload", bus.done, 1'b1);
        doReload();

        $display("[TB] zero length");
        clearLogs();
        frame_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        runFrame(0, -1);
        check("t4_done",    bus.done, 1'b1);
        check("t4_nwrites", dut_addr_log.size(), 0);
        doReload();

        $display("[TB] oversize");
        clearLogs();
        frame_q = '{8'h05, 8'h00, 8'h00, 8'h00};
        runFrame(0, -1);
        check("t5_err",      bus.err,      1'b1);
        check("t5_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        check("t5_nwrites", dut_addr_log.size(), 0);
        doReload();

        $display("[TB] full capacity");
        clearLogs();
        makeFrame(CAP, 1'b0);
        runFrame(0, -1);
        check("t6_done",     bus.done, 1'b1);
        check("t6_nwrites",  dut_addr_log.size(), CAP);
        if (dut_addr_log.size() == CAP)
            check("t6_last_addr", dut_addr_log[CAP-1], CAP - 1);
        doReload();

        $display("[TB] reset mid data");
        clearLogs();
        frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h00, 8'h01,
                    8'h97, 8'h10, 8'h00, 8'h00, 8'h61};
        runFrame(0, 10);
        checkResetValues("t7_rst");
        check("t7_nwrites", dut_addr_log.size(), 1);
        clearLogs();
        frame_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h00, 8'h01, 8'hB9};
        runFrame(0, -1);
        check("t7_done", bus.done, 1'b1);
        if (dut_addr_log.size() == 1) check("t7_addr", dut_addr_log[0], 0);
        else check("t7_nwrites_fresh", dut_addr_log.size(), 1);
        doReload();

        $display("[TB] random frames");
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      n = longint'($urandom_range(0, CAP));
            else if (r < 8) n = longint'($urandom_range(CAP + 1, 2 * CAP));
            else            n = longint'($urandom);
            makeFrame(n, ($urandom_range(0, 3) == 0));
            rst_at = ($urandom_range(0, 9) == 0) ?
                     int'($urandom_range(0, frame_q.size() - 1)) : -1;
            runFrame(int'($urandom_range(0, 50)), rst_at);
            doReload();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
